cnt_seq_ctrl: RTL
=================

Name: cnt_seq_ctrl

Overview:
- Sequencing controller for the 4-bit synchronous up-counter datapath (parallel load, count enable, terminal count).
- Drives the counter's load and enable inputs to generate programmable intervals of p clocks, repeated N times or indefinitely.
- Reports each interval end (tick), run completion (done) and remaining repeats to a host FSM.
- Sits between the host control logic and one counter instance. The counter's Clk and MR are shared with this block.

Parameters:
- CNT_W, 4: counter width; period field width.
- REP_W, 8: repeat-count width.

Ports:
- Clk  in  1  system clock, rising edge.
- MR  in  1  master reset, asynchronous, active-low.
- start  in  1  begin a run; sampled in IDLE only.
- stop  in  1  abort the run; priority over start.
- hold  in  1  freeze counting while high (RUN only).
- period  in  CNT_W  interval length p in clocks; 0 means 2^CNT_W.
- reps  in  REP_W  number of intervals; 0 means periodic (endless).
- cnt_q  in  CNT_W  counter Q, for status only.
- cnt_tc  in  1  counter TC; high when Q is all-ones.
- cnt_pe_n  out  1  counter synchronous parallel load, active-low.
- cnt_ce  out  1  counter count enable.
- cnt_d  out  CNT_W  counter parallel-load value.
- busy  out  1  run in progress.
- tick  out  1  one-clock pulse per completed interval.
- done  out  1  one-clock pulse at the end of a finite run.
- rep_left  out  REP_W  intervals remaining, including the current one.
- irq  out  1  sticky interrupt; see Optional Feature.
- irq_clr  in  1  clears irq.

Behaviour:
- Reset (MR low, asynchronous):
  - state=IDLE; all internal registers 0.
  - Outputs: cnt_pe_n=1, cnt_ce=0, cnt_d=0, busy=0, tick=0, done=0, rep_left=0, irq=0.
- Load value: L = (2^CNT_W - period) mod 2^CNT_W, i.e. two's complement of period. Examples: p=5 gives L=11; p=0 gives L=0 (16 clocks).
- Latching: period and reps are captured into registers in IDLE on start. Later input changes have no effect on the current run.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: start & !stop -> LOAD. Otherwise stay.
  - LOAD: one cycle; cnt_pe_n=0, cnt_d=L, cnt_ce=0, busy=1. Next state RUN.
  - RUN: cnt_ce = !hold; busy=1.
    - Interval end = cnt_tc & cnt_ce.
    - On interval end: cnt_pe_n=0 (combinational), so the counter reloads L on the same edge. Load has priority over count in the counter, which gives gapless back-to-back intervals of exactly p clocks.
    - On interval end with rep_left==1 (finite run): -> DONE.
    - Otherwise rep_left decrements, saturating; in periodic mode it stays 0.
  - DONE: one cycle; done=1, busy=0, cnt_ce=0, cnt_pe_n=1. Next state IDLE.
- tick: registered; high for one cycle after each interval end. The final tick of a finite run coincides with done.
- Latency: first tick occurs p+1 edges after the edge that samples start; subsequent ticks follow every p edges, plus any cycles spent in hold.
- rep_left: loaded with reps in LOAD; decremented on each interval end.
- stop: in LOAD or RUN -> IDLE on the next edge.
  - cnt_ce=0 from that edge onward.
  - No tick, no done.
  - The counter keeps its current Q; the next start reloads it.
- hold with cnt_tc high: no interval end and no load; the counter sits at all-ones until hold is released.
- start while busy: ignored. start and stop in the same cycle in IDLE: stay IDLE.
- MR low mid-run: immediate return to the reset state. No done is produced.

Optional Feature:
- Macro: CNT_SEQ_CTRL_IRQ_EN.
- When defined:
  - irq sets on the cycle done is high.
  - irq holds until irq_clr is high at a clock edge.
  - If set and clear coincide, set wins.
- When undefined: irq is tied 0, irq_clr is ignored, and no flop is inferred. The port list is identical in both builds.

Test Plan:
- MR low at t=10ns, released at t=20ns -> all outputs at reset values; state IDLE; cnt_pe_n=1.
- period=5, reps=3, start one cycle -> cnt_d=11 in LOAD.
  - Ticks at edges +6, +11 and +16 after the start edge.
  - done coincides with the third tick; busy low afterwards.
  - rep_left sequence 3,2,1.
- period=0, reps=2 -> cnt_d=0; ticks spaced 16 clocks apart; done after the second tick.
- period=4, reps=0 (periodic), 40 clocks -> a tick every 4 clocks, never done, rep_left=0.
  - Then stop -> busy low next cycle; no further ticks.
- period=6, reps=1; hold high for 3 cycles while cnt_q=15 -> tick delayed by exactly 3 clocks; no reload during hold.
- Mid-run MR pulse low for 5ns -> outputs reset asynchronously.
  - A new start then runs normally.
  - With CNT_SEQ_CTRL_IRQ_EN defined: irq set at done, cleared by irq_clr.

Source files
------------

// File: rtl/cnt_seq_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnt_seq_ctrl_if : control/status bus between cnt_seq_ctrl and one counter
// Rev 1.0
// ----------------------------------------------------------------------------
interface cnt_seq_ctrl_if #(
    parameter int CNT_W = 4
);
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_tc;
    logic             cnt_pe_n;
    logic             cnt_ce;
    logic [CNT_W-1:0] cnt_d;

    modport master (
        input  cnt_q,
        input  cnt_tc,
        output cnt_pe_n,
        output cnt_ce,
        output cnt_d
    );

    modport slave (
        output cnt_q,
        output cnt_tc,
        input  cnt_pe_n,
        input  cnt_ce,
        input  cnt_d
    );
endinterface
`default_nettype wire

// File: rtl/cnt_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnt_seq_ctrl : sequences an up-counter into p-clock intervals, N times or
//                endlessly. Optional sticky irq via CNT_SEQ_CTRL_IRQ_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module cnt_seq_ctrl #(
    parameter int CNT_W = 4,
    parameter int REP_W = 8
) (
    input  wire logic             Clk,
    input  wire logic             MR,
    input  wire logic             start,
    input  wire logic             stop,
    input  wire logic             hold,
    input  wire logic [CNT_W-1:0] period,
    input  wire logic [REP_W-1:0] reps,
    cnt_seq_ctrl_if.master        cnt,
    output logic                  busy,
    output logic                  tick,
    output logic                  done,
    output logic      [REP_W-1:0] rep_left,
    output logic                  irq,
    input  wire logic             irq_clr
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] C_REP_ONE = REP_W'(1);
    localparam logic [REP_W-1:0] C_REP_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_period;
    logic [REP_W-1:0] r_reps;
    logic [REP_W-1:0] r_rep_left;
    logic             r_tick;
    logic [CNT_W-1:0] w_load_val;
    logic             w_ce;
    logic             w_pe_n;
    logic             w_end;
    logic             w_unused;

    // Two's complement of p: counting up from here reaches all-ones after p-1 clocks
    assign w_load_val = ~r_period + C_CNT_ONE;

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ce   = 1'b0;
        w_pe_n = 1'b1;
        w_end  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_pe_n = stop;
                w_next = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                // stop suppresses counting and the interval end in its own cycle
                w_ce   = !hold && !stop;
                w_end  = cnt.cnt_tc && w_ce;
                w_pe_n = !w_end;
                if (stop) begin
                    w_next = S_IDLE;
                end else if (w_end && (r_rep_left == C_REP_ONE)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            r_period   <= '0;
            r_reps     <= '0;
            r_rep_left <= '0;
            r_tick     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start && !stop) begin
                r_period <= period;
                r_reps   <= reps;
            end
            if (r_state == S_LOAD) begin
                r_rep_left <= r_reps;
            end else if (w_end && (r_rep_left != C_REP_ZERO)) begin
                r_rep_left <= r_rep_left - C_REP_ONE;
            end
            r_tick <= w_end;
        end
    end

    assign cnt.cnt_pe_n = w_pe_n;
    assign cnt.cnt_ce   = w_ce;
    assign cnt.cnt_d    = w_load_val;
    assign tick         = r_tick;
    assign rep_left     = r_rep_left;

`ifdef CNT_SEQ_CTRL_IRQ_EN
    logic r_irq;

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            r_irq <= 1'b0;
        end else if (done) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // Counter Q is status-only here; irq_clr is only consumed in the irq build
    assign w_unused = ^{cnt.cnt_q, irq_clr};

endmodule
`default_nettype wire
